axi_lite_write_slave: RTL



---
 rtl/axi_lite_write_slave.sv | 134 +++++++++++++
 1 files changed

// File: rtl/axi_lite_write_slave.sv
// AXI4-Lite write responder: accepts AW and W independently, applies byte strobes
// to a bank of 32-bit registers and returns one B response per transaction.
module axi_lite_write_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_WIDTH-1:0]    awaddr,
    input  logic                     awvalid,
    output logic                     awready,
    input  logic [31:0]              wdata,
    input  logic [3:0]               wstrb,
    input  logic                     wvalid,
    output logic                     wready,
    output logic [1:0]               bresp,
    output logic                     bvalid,
    input  logic                     bready,
    output logic [32*NUM_REGS-1:0]   reg_out,
    output logic [NUM_REGS-1:0]      wr_pulse,
    output logic                     done
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam logic [IDX_W-1:0] NUM_REGS_IDX = IDX_W'(NUM_REGS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                state;
    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           data_q;
    logic [3:0]            strb_q;
    logic [31:0]           regs [NUM_REGS];

    logic                  aw_hs;
    logic                  w_hs;
    logic [IDX_W-1:0]      idx;
    logic                  legal;

    // Readies are gated by rst_n so they drop the moment reset asserts.
    assign awready = rst_n && (state == IDLE) && !aw_held;
    assign wready  = rst_n && (state == IDLE) && !w_held;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign done    = (state == RESP) && bready;

    assign idx   = addr_q[ADDR_WIDTH-1:2];
    assign legal = (addr_q[1:0] == 2'b00) && (idx < NUM_REGS_IDX);

    // NOTE: every variable assigned in always_comb gets a value on every path
    // (here via the loop covering all indices), otherwise a latch is inferred.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_out[32*i +: 32] = regs[i];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            strb_q   <= '0;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
            wr_pulse <= '0;
            // NOTE: the register bank is software-visible state that must read
            // zero after reset, so it is reset like control flops, not left as RAM.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wr_pulse <= '0;
            case (state)
                IDLE: begin
                    if (aw_hs) begin
                        addr_q  <= awaddr;
                        aw_held <= 1'b1;
                    end
                    if (w_hs) begin
                        data_q <= wdata;
                        strb_q <= wstrb;
                        w_held <= 1'b1;
                    end
                    if ((aw_held || aw_hs) && (w_held || w_hs)) begin
                        state <= WRITE;
                    end
                end

                WRITE: begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (legal && (idx == IDX_W'(i))) begin
                            for (int k = 0; k < 4; k++) begin
                                if (strb_q[k]) begin
                                    regs[i][8*k +: 8] <= data_q[8*k +: 8];
                                end
                            end
                            wr_pulse[i] <= 1'b1;
                        end
                    end
                    bresp  <= legal ? RESP_OKAY : RESP_SLVERR;
                    bvalid <= 1'b1;
                    state  <= RESP;
                end

                RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                        state   <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
